dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, data memory address width.
REQ-002 Parameter: DATA_W, 16, data memory word width.
REQ-003 Clk  input  1  system clock; all state changes on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  processor control unit requests one memory access.
REQ-006 cpu_wr  input  1  processor access is a write (1) or read (0).
REQ-007 cpu_addr  input  ADDR_W  processor access address.
REQ-008 cpu_wdata  input  DATA_W  processor write data.
REQ-009 cpu_gnt  output  1  one-cycle pulse; processor request accepted and latched this cycle.
REQ-010 cpu_rvalid  output  1  rdata holds the processor read result this cycle.
REQ-011 host_req, host_wr, host_addr, host_wdata, host_gnt, host_rvalid: same directions, widths and meanings as REQ-005..REQ-010, for the host/debug loader port.
REQ-012 mem_addr  output  ADDR_W  address to the single-port data memory.
REQ-013 mem_wr  output  1  data memory write enable.
REQ-014 mem_wdata  output  DATA_W  data memory write data.
REQ-015 mem_rdata  input  DATA_W  synchronous-read memory output; valid one cycle after the address is presented.
REQ-016 rdata  output  DATA_W  mem_rdata forwarded to both requesters.
REQ-017 busy  output  1  high in any access state.

Function
REQ-018 The FSM SHALL have five states: IDLE, CPU_A, CPU_B, HOST_A, HOST_B.
REQ-019 Each access SHALL take exactly two cycles: in X_A the latched address is driven; in X_B the address stays held, mem_wr=1 for writes, and X_rvalid=1 for reads.
REQ-020 Arbitration SHALL occur only in IDLE and in CPU_B/HOST_B, so back-to-back accesses run with no idle cycle.
REQ-021 In an arbitration cycle with a single requester, that requester's gnt SHALL pulse and the next state SHALL be its A state.
REQ-022 With both requesting, the grant SHALL go to the port not served last (round-robin pointer last_host, updated on every grant).
REQ-023 On a grant edge, addr, wr and wdata of the winning port SHALL be captured into internal registers; the requester may drop or change its inputs from the next cycle.
REQ-024 Latency: req high in IDLE in cycle N -> gnt in N, X_A in N+1, X_B in N+2 (mem_wr or rvalid in N+2).
REQ-025 A request held high outside an arbitration cycle SHALL be ignored until the next arbitration cycle; no gnt SHALL pulse in A states.
REQ-026 If no request is present in X_B, the next state SHALL be IDLE.
REQ-027 mem_addr SHALL be 0, mem_wr 0, mem_wdata 0 and both rvalid 0 in IDLE.
REQ-028 mem_wr SHALL never be asserted outside CPU_B/HOST_B, and at most one rvalid SHALL be high in any cycle.
REQ-029 rdata SHALL equal mem_rdata in every cycle; only rvalid qualifies it.
REQ-030 A port's gnt and its own rvalid MAY be high in the same cycle (back-to-back from the same port when the other port is idle).

Reset
REQ-031 On Reset=1 at a clock edge: state IDLE, last_host=1 (processor wins the first tie), latched addr/wr/wdata 0.
REQ-032 Outputs are decoded from state; with Reset=1 during X_B that cycle's write or read completes, and IDLE follows with no gnt pulse.
REQ-033 No gnt SHALL pulse in any cycle where Reset=1.

Verification
REQ-034 Processor read addr 0x12 from IDLE, mem holds 0xBEEF -> cpu_gnt cycle N, mem_addr=0x12 in N+1..N+2, cpu_rvalid with rdata=0xBEEF in N+2, IDLE in N+3.
REQ-035 Host write 0x5A to addr 0x40 -> mem_wr=1 only in cycle N+2 with mem_addr=0x40, mem_wdata=0x005A; host_req dropped in N+1 has no effect.
REQ-036 Both requests high continuously after reset -> grant order CPU, HOST, CPU, HOST; one access every two cycles, no IDLE between.
REQ-037 cpu_req held high for 3 accesses, host idle -> CPU_A/CPU_B repeat; cpu_gnt pulses in N, N+2, N+4.
REQ-038 Reset asserted during HOST_A of a write -> mem_wr never asserted; IDLE next cycle; a subsequent tie is granted to CPU.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory between processor and host ports.
// Grant is same-cycle; each access takes 2 cycles (A: addr, B: write/rvalid); a losing request waits for the next arbitration cycle.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CPU_A  = 3'd1,
        S_CPU_B  = 3'd2,
        S_HOST_A = 3'd3,
        S_HOST_B = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_last_host;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_arb;
    logic                w_cpu_gnt;
    logic                w_host_gnt;
    logic                w_b_state;

    assign w_arb = (r_state == S_IDLE) || (r_state == S_CPU_B) || (r_state == S_HOST_B);

    // On a tie the port not served last wins; Reset suppresses any grant.
    assign w_cpu_gnt  = w_arb && !Reset && cpu_req  && (!host_req || r_last_host);
    assign w_host_gnt = w_arb && !Reset && host_req && (!cpu_req  || !r_last_host);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_last_host <= 1'b1;
            r_addr      <= '0;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_CPU_B, S_HOST_B: begin
                    if (w_cpu_gnt) begin
                        r_state     <= S_CPU_A;
                        r_last_host <= 1'b0;
                        r_addr      <= cpu_addr;
                        r_wr        <= cpu_wr;
                        r_wdata     <= cpu_wdata;
                    end else if (w_host_gnt) begin
                        r_state     <= S_HOST_A;
                        r_last_host <= 1'b1;
                        r_addr      <= host_addr;
                        r_wr        <= host_wr;
                        r_wdata     <= host_wdata;
                    end else begin
                        r_state     <= S_IDLE;
                    end
                end
                S_CPU_A:  r_state <= S_CPU_B;
                S_HOST_A: r_state <= S_HOST_B;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Memory-side outputs follow state only, so a B cycle under Reset still completes.
    assign w_b_state   = (r_state == S_CPU_B) || (r_state == S_HOST_B);
    assign busy        = (r_state != S_IDLE);
    assign mem_addr    = busy ? r_addr  : '0;
    assign mem_wdata   = busy ? r_wdata : '0;
    assign mem_wr      = w_b_state && r_wr;
    assign cpu_rvalid  = (r_state == S_CPU_B)  && !r_wr;
    assign host_rvalid = (r_state == S_HOST_B) && !r_wr;
    assign cpu_gnt     = w_cpu_gnt;
    assign host_gnt    = w_host_gnt;
    assign rdata       = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Vector bench for dmem_arbiter with a behavioural synchronous-read memory.
module tb_dmem_arbiter;

    logic        Clk;
    logic        Reset;
    logic        cpu_req, cpu_wr, host_req, host_wr;
    logic [7:0]  cpu_addr, host_addr, mem_addr;
    logic [15:0] cpu_wdata, host_wdata, mem_wdata, mem_rdata, rdata;
    logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_wr, busy;

    logic [15:0] mem [256];

    int tests  = 0;
    int failed = 0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rdata(rdata), .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // flags = {cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_wr, busy}
    typedef struct {
        logic        rst;
        logic [1:0]  c;
        logic [7:0]  caddr;
        logic [15:0] cwd;
        logic [1:0]  h;
        logic [7:0]  haddr;
        logic [15:0] hwd;
        logic [5:0]  flags;
        logic [7:0]  maddr;
        logic [15:0] mwd;
        logic [15:0] rd;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic rst, input logic [1:0] c, input logic [7:0] caddr,
                     input logic [15:0] cwd, input logic [1:0] h, input logic [7:0] haddr,
                     input logic [15:0] hwd, input logic [5:0] flags, input logic [7:0] maddr,
                     input logic [15:0] mwd, input logic [15:0] rd);
        vec_t t;
        t.rst = rst; t.c = c; t.caddr = caddr; t.cwd = cwd;
        t.h = h; t.haddr = haddr; t.hwd = hwd;
        t.flags = flags; t.maddr = maddr; t.mwd = mwd; t.rd = rd;
        vq.push_back(t);
    endtask

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [5:0]  act_flags;
        logic [5:0]  gnt_mask;

        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[8'h12] = 16'hBEEF;

        Reset = 1'b1;
        cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_wr = 0; host_addr = 0; host_wdata = 0;
        repeat (2) @(negedge Clk);

        // reset behaviour, single processor read, single host write
        v(1, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b000000, 8'h00, 16'h0000, 16'h0);
        v(1, 2'b10, 8'h12, 16'h0000, 2'b10, 8'h13, 16'h0000, 6'b000000, 8'h00, 16'h0000, 16'h0);
        v(0, 2'b10, 8'h12, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b100000, 8'h00, 16'h0000, 16'h0);
        v(0, 2'b00, 8'h99, 16'h5555, 2'b00, 8'h00, 16'h0000, 6'b000001, 8'h12, 16'h0000, 16'h0);
        v(0, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b001001, 8'h12, 16'h0000, 16'hBEEF);
        v(0, 2'b00, 8'h00, 16'h0000, 2'b11, 8'h40, 16'h005A, 6'b010000, 8'h00, 16'h0000, 16'h0);
        v(0, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h41, 16'hFFFF, 6'b000001, 8'h40, 16'h005A, 16'h0);
        v(0, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b000011, 8'h40, 16'h005A, 16'h0);
        // continuous tie alternates CPU, HOST, CPU with no idle gap
        v(1, 2'b10, 8'h40, 16'h0000, 2'b10, 8'h13, 16'h0000, 6'b000000, 8'h00, 16'h0000, 16'h0);
        v(0, 2'b10, 8'h40, 16'h0000, 2'b10, 8'h13, 16'h0000, 6'b100000, 8'h00, 16'h0000, 16'h0);
        v(0, 2'b10, 8'h40, 16'h0000, 2'b10, 8'h13, 16'h0000, 6'b000001, 8'h40, 16'h0000, 16'h0);
        v(0, 2'b10, 8'h40, 16'h0000, 2'b10, 8'h13, 16'h0000, 6'b011001, 8'h40, 16'h0000, 16'h005A);
        v(0, 2'b10, 8'h40, 16'h0000, 2'b10, 8'h13, 16'h0000, 6'b000001, 8'h13, 16'h0000, 16'h0);
        v(0, 2'b10, 8'h40, 16'h0000, 2'b10, 8'h13, 16'h0000, 6'b100101, 8'h13, 16'h0000, 16'h1013);
        v(0, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b000001, 8'h40, 16'h0000, 16'h0);
        v(0, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b001001, 8'h40, 16'h0000, 16'h005A);
        // back-to-back processor accesses, host idle
        v(0, 2'b11, 8'h20, 16'hAAAA, 2'b00, 8'h00, 16'h0000, 6'b100000, 8'h00, 16'h0000, 16'h0);
        v(0, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b000001, 8'h20, 16'hAAAA, 16'h0);
        v(0, 2'b11, 8'h21, 16'hBBBB, 2'b00, 8'h00, 16'h0000, 6'b100011, 8'h20, 16'hAAAA, 16'h0);
        v(0, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b000001, 8'h21, 16'hBBBB, 16'h0);
        v(0, 2'b10, 8'h20, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b100011, 8'h21, 16'hBBBB, 16'h0);
        v(0, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b000001, 8'h20, 16'h0000, 16'h0);
        // Reset in CPU_B: read still completes, no grant; pointer returns to CPU-first
        v(1, 2'b10, 8'h55, 16'h0000, 2'b10, 8'h55, 16'h0000, 6'b001001, 8'h20, 16'h0000, 16'hAAAA);
        v(0, 2'b10, 8'h12, 16'h0000, 2'b11, 8'h30, 16'h1111, 6'b100000, 8'h00, 16'h0000, 16'h0);
        v(0, 2'b10, 8'h12, 16'h0000, 2'b11, 8'h30, 16'h1111, 6'b000001, 8'h12, 16'h0000, 16'h0);
        v(0, 2'b10, 8'h12, 16'h0000, 2'b11, 8'h30, 16'h1111, 6'b011001, 8'h12, 16'h0000, 16'hBEEF);
        // Reset in HOST_A of a write: write is abandoned
        v(1, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b000001, 8'h30, 16'h1111, 16'h0);
        v(0, 2'b10, 8'h30, 16'h0000, 2'b10, 8'h12, 16'h0000, 6'b100000, 8'h00, 16'h0000, 16'h0);
        v(0, 2'b10, 8'h30, 16'h0000, 2'b10, 8'h12, 16'h0000, 6'b000001, 8'h30, 16'h0000, 16'h0);
        v(0, 2'b10, 8'h30, 16'h0000, 2'b10, 8'h12, 16'h0000, 6'b011001, 8'h30, 16'h0000, 16'h1030);
        v(0, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b000001, 8'h12, 16'h0000, 16'h0);
        v(0, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b000101, 8'h12, 16'h0000, 16'hBEEF);
        v(0, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 6'b000000, 8'h00, 16'h0000, 16'h0);

        foreach (vq[i]) begin
            Reset      = vq[i].rst;
            cpu_req    = vq[i].c[1];  cpu_wr  = vq[i].c[0];
            cpu_addr   = vq[i].caddr; cpu_wdata  = vq[i].cwd;
            host_req   = vq[i].h[1];  host_wr = vq[i].h[0];
            host_addr  = vq[i].haddr; host_wdata = vq[i].hwd;
            #1;
            act_flags = {cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_wr, busy};
            check($sformatf("row%0d flags/addr/wdata", i),
                  {8'h0, act_flags, 2'b0, mem_addr, mem_wdata},
                  {8'h0, vq[i].flags, 2'b0, vq[i].maddr, vq[i].mwd});
            if (vq[i].flags[3] || vq[i].flags[2])
                check($sformatf("row%0d rdata", i), {24'h0, rdata}, {24'h0, vq[i].rd});
            @(negedge Clk);
        end

        // processor request held from idle: grants every other cycle
        Reset = 0; cpu_req = 1; cpu_wr = 0; cpu_addr = 8'h00;
        gnt_mask = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            gnt_mask[k] = cpu_gnt;
            @(negedge Clk);
        end
        check("held cpu_req grant cycles", {34'h0, gnt_mask}, {34'h0, 6'b010101});
        cpu_req = 0;
        repeat (3) @(negedge Clk);
        check("idle after held req", {39'h0, busy}, 40'h0);

        check("mem[0x40] host write", {24'h0, mem[8'h40]}, {24'h0, 16'h005A});
        check("mem[0x21] cpu write",  {24'h0, mem[8'h21]}, {24'h0, 16'hBBBB});
        check("mem[0x30] untouched",  {24'h0, mem[8'h30]}, {24'h0, 16'h1030});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
